// File: rtl/sd_card_timer_mc.sv
// Multi-channel Avalon-MM down-counting interval timer with per-channel STATUS/CONTROL/PERIOD/SNAP.
// Optional per-channel 8-bit tick prescaler is enabled by defining SD_TIMER_PRESCALER_EN.
module sd_card_timer_mc #(
    parameter int NUM_CH     = 2,
    parameter int CNT_W      = 32,
    parameter int PERIOD_RST = 49999
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              chipselect,
    input  logic [3:0]        address,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [NUM_CH-1:0] irq
);
    localparam logic [CNT_W-1:0] PER_INIT = CNT_W'(PERIOD_RST);

    logic        wr_en;
    logic [31:0] rd_ch [NUM_CH];
    logic [31:0] rd_next;

    assign wr_en = chipselect & ~write_n;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic             sel;
        logic             wr_status, wr_ctrl, wr_period, wr_snap;
        logic             start, stop, tick, wrap;
        logic [CNT_W-1:0] count, period, snap;
        logic             ito, cont, to, run, reload_pend;
        logic [7:0]       presc, pcnt;

        assign sel       = wr_en && (address[3:2] == 2'(g));
        assign wr_status = sel && (address[1:0] == 2'd0);
        assign wr_ctrl   = sel && (address[1:0] == 2'd1);
        assign wr_period = sel && (address[1:0] == 2'd2);
        assign wr_snap   = sel && (address[1:0] == 2'd3);
        assign start     = wr_ctrl && writedata[2];
        assign stop      = wr_ctrl && writedata[3];
        // The forced reload after a PERIOD write owns the count for that cycle.
        assign tick      = run && (pcnt == 8'd0) && !reload_pend;
        assign wrap      = tick && (count == '0);

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                count       <= PER_INIT;
                period      <= PER_INIT;
                snap        <= '0;
                ito         <= 1'b0;
                cont        <= 1'b0;
                to          <= 1'b0;
                run         <= 1'b0;
                reload_pend <= 1'b0;
            end else begin
                reload_pend <= wr_period;
                if (wr_ctrl) begin
                    ito  <= writedata[0];
                    cont <= writedata[1];
                end
                if (wr_period)
                    period <= writedata[CNT_W-1:0];
                if (wr_snap)
                    snap <= count;

                if (reload_pend || wrap)
                    count <= period;
                else if (tick)
                    count <= count - 1'b1;

                if (wr_status)
                    to <= 1'b0;
                else if (wrap)
                    to <= 1'b1;

                if (start)
                    run <= 1'b1;
                else if (stop || reload_pend || (wrap && !cont))
                    run <= 1'b0;
            end
        end

`ifdef SD_TIMER_PRESCALER_EN
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                presc <= 8'd0;
                pcnt  <= 8'd0;
            end else begin
                if (wr_ctrl)
                    presc <= writedata[15:8];
                // START takes the PRESC value being written alongside it.
                if (start)
                    pcnt <= writedata[15:8];
                else if (reload_pend)
                    pcnt <= presc;
                else if (run)
                    pcnt <= (pcnt == 8'd0) ? presc : pcnt - 8'd1;
            end
        end
`else
        assign presc = 8'd0;
        assign pcnt  = 8'd0;
`endif

        always_comb begin
            rd_ch[g] = '0;
            case (address[1:0])
                2'd0:    rd_ch[g] = {30'd0, run, to};
                2'd1:    rd_ch[g] = {16'd0, presc, 6'd0, cont, ito};
                2'd2:    rd_ch[g] = 32'(period);
                default: rd_ch[g] = 32'(snap);
            endcase
        end

        assign irq[g] = to & ito;
    end

    // Channels beyond NUM_CH never match, so they read back as 0.
    always_comb begin
        rd_next = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (address[3:2] == 2'(i))
                rd_next = rd_ch[i];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            readdata <= '0;
        else
            readdata <= rd_next;
    end

endmodule

// File: doc/sd_card_timer_mc.md
SD_CARD_TIMER_MC -- requirements
Module: sd_card_timer_mc

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, giving the number of independent timer channels (1..4).
REQ-002 SHALL have parameter CNT_W, default 32, giving the counter and period width in bits (8..32).
REQ-003 SHALL have parameter PERIOD_RST, default 49999, giving the reset period and reset count of every channel.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; reset is asynchronous and active-low.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port chipselect, input, 1 bit: Avalon slave select.
REQ-007 SHALL have port address, input, 4 bits: word address {channel[1:0], reg[1:0]}.
REQ-008 SHALL have port write_n, input, 1 bit: active-low write strobe.
REQ-009 SHALL have port writedata, input, 32 bits: write data.
REQ-010 SHALL have port readdata, output, 32 bits: registered read data.
REQ-011 SHALL have port irq, output, NUM_CH bits: per-channel interrupt.

Function
REQ-012 SHALL use this per-channel register map: reg0 STATUS (bit0 TO, bit1 RUN), reg1 CONTROL (bit0 ITO, bit1 CONT, bit2 START, bit3 STOP, bits15:8 PRESC), reg2 PERIOD, reg3 SNAP.
REQ-013 SHALL treat accesses to a channel index >= NUM_CH as no-ops, with a read value of 0.
REQ-014 SHALL register readdata one cycle after the address is presented, every cycle whether or not chipselect is asserted; unused bits read 0 and the count is zero-extended from CNT_W.
REQ-015 SHALL clear TO on any write to STATUS; if a clear and a timeout occur in the same cycle, the clear wins.
REQ-016 SHALL store writedata[1:0] and writedata[15:8] on a CONTROL write; START and STOP are write-only pulses and read 0.
REQ-017 SHALL set RUN on START; SHALL clear RUN on STOP; if both are written together, START wins.
REQ-018 SHALL store writedata[CNT_W-1:0] on a PERIOD write, then on the next cycle load the count with the new period and clear RUN (force reload).
REQ-019 SHALL capture the live count into SNAP on a SNAP write; a SNAP read returns the captured value.
REQ-020 SHALL define a tick as: RUN=1 and the prescaler count equal to 0.
REQ-021 SHALL decrement the count by 1 on each tick while count != 0.
REQ-022 SHALL, on a tick with count == 0: reload the count with PERIOD, set TO, and clear RUN if CONT=0, giving PERIOD+1 ticks between timeouts.
REQ-023 SHALL hold the count while RUN=0; START resumes counting from the held count.
REQ-024 SHALL drive irq[n] = TO[n] AND ITO[n] combinationally from registered state.
REQ-025 SHALL operate all channels fully independently; simultaneous writes are impossible, but simultaneous timeouts on several channels SHALL all be recorded.
REQ-026 SHALL ensure that a PERIOD write arriving in the same cycle as a timeout reload makes the new period win on the following cycle.

Reset
REQ-027 SHALL, while reset_n=0: set count and PERIOD to PERIOD_RST[CNT_W-1:0]; clear SNAP, CONTROL, TO, RUN, the prescaler, readdata and irq.
REQ-028 SHALL take effect immediately on assertion of reset, including mid-count, and SHALL require a START after release.

Configuration
REQ-029 SHALL, with macro SD_TIMER_PRESCALER_EN defined: hold a per-channel 8-bit prescaler that loads PRESC on START, on force reload and when it reaches 0, and decrements each clock while RUN=1, so ticks occur every PRESC+1 clocks.
REQ-030 SHALL, without SD_TIMER_PRESCALER_EN: omit the prescaler logic so the prescaler count is constant 0 (tick every clock while RUN=1), and make PRESC read 0 with writes ignored.

Verification
REQ-031 SHALL cover: ch0 PERIOD=4, CONTROL=0x7 -> TO and irq[0] rise 5 clocks after START; they recur every 5 clocks; RUN stays 1.
REQ-032 SHALL cover: ch1 PERIOD=3, CONTROL=0x4 (one-shot) -> TO=1 and RUN=0 after 4 ticks; count = 3; irq[1]=0 because ITO=0.
REQ-033 SHALL cover: a STATUS write in the same cycle as a timeout -> TO=0 afterwards; a STATUS read returns 0x2 in continuous mode.
REQ-034 SHALL cover: a PERIOD=100 write while running -> the next cycle shows count=100 and RUN=0; START resumes from 100.
REQ-035 SHALL cover: a SNAP write while count=37 -> a SNAP read returns 37 after 1-cycle read latency; a read of channel 3 with NUM_CH=2 returns 0.
REQ-036 SHALL cover: with SD_TIMER_PRESCALER_EN, PRESC=2 and PERIOD=1 -> the first timeout after 6 clocks; reset_n pulsed mid-count -> all registers return to reset values.
